// File: rtl/lab2_proc_bypass_scoreboard_pkg.sv
// Shared types for the lab2 bypass scoreboard: per-stage writer entry and sel encoding.
// Entry fields use fixed maximum widths so one struct serves every parameterisation.
package lab2_proc_sb_pkg;

  localparam int SB_RW_MAX = 8;
  localparam int SB_AW_MAX = 8;
  localparam int SB_SEL_RF = 0;

  typedef struct packed {
    logic                 val;
    logic [SB_RW_MAX-1:0] rd;
    logic                 wen;
    logic [SB_AW_MAX-1:0] avail;
  } sb_entry_t;

  // Stage s bypass is encoded as s+1 so that 0 stays free for the regfile.
  function automatic int sb_stage_to_sel(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/lab2_proc_bypass_scoreboard_if.sv
// D-stage / pipeline-control bundle between the processor control unit and the scoreboard.
interface lab2_proc_bypass_scoreboard_if #(
  parameter int p_nstages = 3,
  parameter int p_nregs   = 32
);
  localparam int RW = $clog2(p_nregs);
  localparam int AW = $clog2(p_nstages);
  localparam int SW = $clog2(p_nstages + 1);

  logic                 go_D;
  logic [RW-1:0]        rd_D;
  logic                 wen_D;
  logic [AW-1:0]        avail_D;
  logic [RW-1:0]        rs1_D;
  logic [RW-1:0]        rs2_D;
  logic                 rs1_en_D;
  logic                 rs2_en_D;
  logic [p_nstages-1:0] adv;
  logic                 stall_D;
  logic [SW-1:0]        rs1_sel_D;
  logic [SW-1:0]        rs2_sel_D;
  logic [31:0]          num_stall_cyc;
  logic [31:0]          num_bypass;

  modport master (
    output go_D, rd_D, wen_D, avail_D, rs1_D, rs2_D, rs1_en_D, rs2_en_D, adv,
    input  stall_D, rs1_sel_D, rs2_sel_D, num_stall_cyc, num_bypass
  );

  modport slave (
    input  go_D, rd_D, wen_D, avail_D, rs1_D, rs2_D, rs1_en_D, rs2_en_D, adv,
    output stall_D, rs1_sel_D, rs2_sel_D, num_stall_cyc, num_bypass
  );

endinterface

// File: rtl/lab2_proc_bypass_scoreboard_lookup.sv
// One source operand's hazard lookup: finds the youngest in-flight writer of the
// register and decides regfile read, bypass from that stage, or stall.
module lab2_proc_sb_lookup
  import lab2_proc_sb_pkg::*;
#(
  parameter int p_nstages = 3,
  parameter int p_nregs   = 32,
  localparam int RW = $clog2(p_nregs),
  localparam int SW = $clog2(p_nstages + 1)
)(
  input  sb_entry_t [p_nstages-1:0] i_entries,
  input  logic [RW-1:0]             i_src,
  input  logic                      i_en,
  output logic [SW-1:0]             o_sel,
  output logic                      o_stall
);

  logic                 w_hit;
  int                   w_stage;
  logic [SB_AW_MAX-1:0] w_avail;

  // Scan oldest to youngest so the last hit recorded is the youngest writer.
  always_comb begin
    w_hit   = 1'b0;
    w_stage = 0;
    w_avail = '0;
    if (i_en && (i_src != '0)) begin
      for (int s = p_nstages - 1; s >= 0; s--) begin
        if (i_entries[s].val && i_entries[s].wen &&
            (i_entries[s].rd == SB_RW_MAX'(i_src))) begin
          w_hit   = 1'b1;
          w_stage = s;
          w_avail = i_entries[s].avail;
        end
      end
    end
  end

  always_comb begin
    o_sel   = SW'(SB_SEL_RF);
    o_stall = 1'b0;
    if (w_hit) begin
      if (SB_AW_MAX'(w_stage) >= w_avail)
        o_sel = SW'(sb_stage_to_sel(w_stage));
      else
        o_stall = 1'b1;
    end
  end

endmodule

// File: rtl/lab2_proc_bypass_scoreboard.sv
// Hazard/bypass scoreboard for the lab2 pipeline: shift array of in-flight writers plus two lookups.
// Optional statistics counters are enabled by defining LAB2_PROC_SCOREBOARD_STATS_EN.
module lab2_proc_bypass_scoreboard
  import lab2_proc_sb_pkg::*;
#(
  parameter int p_nstages = 3,
  parameter int p_nregs   = 32,
  localparam int SW = $clog2(p_nstages + 1)
)(
  input logic clk,
  input logic reset,
  lab2_proc_bypass_scoreboard_if.slave sb
);

  sb_entry_t [p_nstages-1:0] r_entries;
  sb_entry_t                 w_new;
  logic [SW-1:0]             w_sel1;
  logic [SW-1:0]             w_sel2;
  logic                      w_stall1;
  logic                      w_stall2;
  logic                      w_stall;

  always_comb begin
    w_new       = '0;
    w_new.val   = 1'b1;
    w_new.rd    = SB_RW_MAX'(sb.rd_D);
    w_new.wen   = sb.wen_D;
    w_new.avail = SB_AW_MAX'(sb.avail_D);
  end

  // Bubbles propagate with adv, so a moving stage copies its predecessor even when invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_entries <= '0;
    end else begin
      if (sb.go_D)
        r_entries[0] <= w_new;
      else if (sb.adv[0])
        r_entries[0].val <= 1'b0;
      for (int s = 1; s < p_nstages; s++) begin
        if (sb.adv[s-1])
          r_entries[s] <= r_entries[s-1];
        else if (sb.adv[s])
          r_entries[s].val <= 1'b0;
      end
    end
  end

  lab2_proc_sb_lookup #(.p_nstages(p_nstages), .p_nregs(p_nregs)) u_lookup_rs1 (
    .i_entries (r_entries),
    .i_src     (sb.rs1_D),
    .i_en      (sb.rs1_en_D),
    .o_sel     (w_sel1),
    .o_stall   (w_stall1)
  );

  lab2_proc_sb_lookup #(.p_nstages(p_nstages), .p_nregs(p_nregs)) u_lookup_rs2 (
    .i_entries (r_entries),
    .i_src     (sb.rs2_D),
    .i_en      (sb.rs2_en_D),
    .o_sel     (w_sel2),
    .o_stall   (w_stall2)
  );

  assign w_stall      = w_stall1 | w_stall2;
  assign sb.stall_D   = w_stall;
  assign sb.rs1_sel_D = w_stall ? SW'(SB_SEL_RF) : w_sel1;
  assign sb.rs2_sel_D = w_stall ? SW'(SB_SEL_RF) : w_sel2;

`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
  logic [31:0] r_num_stall_cyc;
  logic [31:0] r_num_bypass;
  logic [1:0]  w_byp_inc;
  logic [32:0] w_byp_sum;

  assign w_byp_inc = {1'b0, (sb.rs1_sel_D != '0)} + {1'b0, (sb.rs2_sel_D != '0)};
  assign w_byp_sum = {1'b0, r_num_bypass} + 33'(w_byp_inc);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_stall_cyc <= '0;
      r_num_bypass    <= '0;
    end else begin
      if (w_stall && (r_num_stall_cyc != 32'hFFFF_FFFF))
        r_num_stall_cyc <= r_num_stall_cyc + 32'd1;
      if (sb.go_D)
        r_num_bypass <= w_byp_sum[32] ? 32'hFFFF_FFFF : w_byp_sum[31:0];
    end
  end

  assign sb.num_stall_cyc = r_num_stall_cyc;
  assign sb.num_bypass    = r_num_bypass;
`else
  assign sb.num_stall_cyc = 32'd0;
  assign sb.num_bypass    = 32'd0;
`endif

endmodule

// File: tb/tb_lab2_proc_bypass_scoreboard.sv
// Directed self-checking bench for lab2_proc_bypass_scoreboard with p_nstages=3, p_nregs=32.
module tb_lab2_proc_bypass_scoreboard;

  localparam int N = 3;

`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
  localparam int EXP_STALLS  = 2;
  localparam int EXP_BYPASSES = 1;
`else
  localparam int EXP_STALLS  = 0;
  localparam int EXP_BYPASSES = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int nChecks = 0;
  int nPass = 0;
  logic [N-1:0] mVal = '0;

  always #5 clk = ~clk;

  lab2_proc_bypass_scoreboard_if #(.p_nstages(N), .p_nregs(32)) sbIf ();

  lab2_proc_bypass_scoreboard #(.p_nstages(N), .p_nregs(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbIf.slave)
  );

  task automatic applyStimulus(input logic go, input int rd, input logic wen, input int avail,
                               input logic [N-1:0] adv, input int rs1, input logic en1,
                               input int rs2, input logic en2);
    sbIf.go_D     = go;
    sbIf.rd_D     = 5'(rd);
    sbIf.wen_D    = wen;
    sbIf.avail_D  = 2'(avail);
    sbIf.adv      = adv;
    sbIf.rs1_D    = 5'(rs1);
    sbIf.rs1_en_D = en1;
    sbIf.rs2_D    = 5'(rs2);
    sbIf.rs2_en_D = en2;
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag, input logic expStall, input int expSel1, input int expSel2);
    checkVal({tag, ".stall"}, 32'(sbIf.stall_D), 32'(expStall));
    checkVal({tag, ".sel1"},  32'(sbIf.rs1_sel_D), 32'(expSel1));
    checkVal({tag, ".sel2"},  32'(sbIf.rs2_sel_D), 32'(expSel2));
  endtask

  // Advance one clock; also enforces the adv contract on the stimulus using a shadow of valid bits.
  task automatic tick();
    logic viol = 1'b0;
    for (int s = 0; s < N - 1; s++)
      if (sbIf.adv[s] && mVal[s] && !sbIf.adv[s+1] && mVal[s+1]) viol = 1'b1;
    if (!reset) begin
      assert (!viol) else $error("[TB] FAIL protocol: adv=%b val=%b", sbIf.adv, mVal);
    end
    if (reset) begin
      mVal = '0;
    end else begin
      for (int s = N - 1; s >= 1; s--) begin
        if (sbIf.adv[s-1]) mVal[s] = mVal[s-1];
        else if (sbIf.adv[s]) mVal[s] = 1'b0;
      end
      if (sbIf.go_D) mVal[0] = 1'b1;
      else if (sbIf.adv[0]) mVal[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    applyStimulus(0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
    repeat (N) tick();
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 0, 0, 3'b000, 5, 1, 7, 1);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset", 0, 0, 0);
    checkVal("reset.stallcnt", sbIf.num_stall_cyc, 0);
    checkVal("reset.bypcnt",   sbIf.num_bypass, 0);

    // 1: ALU writer in X bypasses from X
    applyStimulus(1, 5, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 5, 1, 0, 0);
    checkOutput("t1.aluX", 0, 1, 0);
    flush();

    // 2: load in X stalls, then bypasses from M
    applyStimulus(1, 7, 1, 1, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 7, 1);
    checkOutput("t2.loadX", 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b001, 0, 0, 7, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 7, 1);
    checkOutput("t2.loadM", 0, 0, 2);
    flush();

    // 3: r0 writer and non-writing instruction never bypass
    applyStimulus(1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 0, 0);
    checkOutput("t3.r0", 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 3'b001, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 4, 1, 0, 0);
    checkOutput("t3.nowen", 0, 0, 0);
    flush();

    // 4: youngest writer wins
    applyStimulus(1, 3, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 3, 1, 0, 3'b001, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 3, 1, 3, 1);
    checkOutput("t4.youngest", 0, 1, 1);
    flush();

    // 5: W bypass, retirement, then stall-hold with entries in every stage
    applyStimulus(1, 9, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 9, 1, 0, 0);
    checkOutput("t5.inW", 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 9, 1, 0, 0);
    checkOutput("t5.retired", 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 2, 1, 0, 3'b001, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 6, 1, 0, 3'b011, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 1, 1, 2, 1);
    repeat (3) tick();
    checkOutput("t5.holdWM", 0, 3, 2);
    applyStimulus(0, 0, 0, 0, 3'b000, 6, 1, 0, 0);
    checkOutput("t5.holdX", 0, 1, 0);

    // 6: mid-operation reset drops every entry, then stats
    reset = 1'b1;
    applyStimulus(1, 11, 1, 0, 3'b111, 6, 1, 2, 1);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 3'b000, 6, 1, 2, 1);
    checkOutput("t6.reset", 0, 0, 0);
    applyStimulus(1, 8, 1, 1, 3'b000, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 8, 1, 0, 0);
    checkOutput("t6.stall", 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b001, 8, 1, 0, 0);
    tick();
    applyStimulus(1, 10, 1, 0, 3'b000, 8, 1, 0, 0);
    checkOutput("t6.bypgo", 0, 2, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checkVal("t6.stallcnt", sbIf.num_stall_cyc, 32'(EXP_STALLS));
    checkVal("t6.bypcnt",   sbIf.num_bypass, 32'(EXP_BYPASSES));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
